// File: rtl/filter_weight_buffer.sv
// Double-buffered convolution weight store: words stream into the shadow bank while the active bank feeds the MAC array.
// Optional checksum-word validation of each load is enabled by defining FILTER_WEIGHT_CKSUM_EN.
module filter_weight_buffer #(
  parameter int WIDTH = 8,
  parameter int K     = 3,
  parameter int CH    = 3,
  parameter int NF    = 4,
  localparam int N    = NF * K * K * CH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 swap_req,
  output logic [N*WIDTH-1:0]   weights,
  output logic                 weights_valid,
  output logic                 active_bank,
  output logic                 shadow_full,
  output logic                 load_err
);

`ifdef FILTER_WEIGHT_CKSUM_EN
  localparam int LAST_IDX = N;
`else
  localparam int LAST_IDX = N - 1;
`endif
  localparam int CNTW = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_count;
  logic              r_active;
  logic              r_weights_valid;
  logic              r_load_err;
  logic [WIDTH-1:0]  r_bank [2][N];

  state_t            w_state_nxt;
  logic [CNTW-1:0]   w_count_nxt;
  logic              w_accept;
  logic              w_at_last;
  logic              w_wr_en;
  logic              w_err;
  logic              w_swap;
  logic              w_shadow;
  logic              w_last_ok;

  assign w_accept  = in_valid && (r_state != FULL);
  assign w_at_last = (r_count == CNTW'(LAST_IDX));
  assign w_shadow  = ~r_active;

`ifdef FILTER_WEIGHT_CKSUM_EN
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;

  // The checksum word sits one past the last weight and is never stored.
  assign w_wr_en   = w_accept && !w_at_last;
  assign w_last_ok = in_last && (in_data == r_acc);

  always_comb begin
    w_acc_nxt = r_acc;
    if (w_wr_en) begin
      w_acc_nxt = ((r_count == '0) ? '0 : r_acc) + in_data;
    end
  end
`else
  assign w_wr_en   = w_accept;
  assign w_last_ok = in_last;
`endif

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err       = 1'b0;
    w_swap      = 1'b0;
    unique case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          if (w_at_last) begin
            if (w_last_ok) begin
              w_state_nxt = FULL;
              w_count_nxt = '0;
            end else begin
              w_err = 1'b1;
            end
          end else if (in_last) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = LOAD;
            w_count_nxt = r_count + CNTW'(1);
          end
        end
      end
      FULL: begin
        if (swap_req) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_err) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end
  end

  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_count         <= '0;
      r_active        <= 1'b0;
      r_weights_valid <= 1'b0;
      r_load_err      <= 1'b0;
      // NOTE: the banks are reset on purpose: weights must read as zero after
      // reset, and a load interrupted by reset must leave no stale words.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_load_err <= w_err;
      if (w_swap) begin
        r_active        <= ~r_active;
        r_weights_valid <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (w_wr_en && (r_count == CNTW'(i))) begin
          r_bank[w_shadow][i] <= in_data;
        end
      end
    end
  end

`ifdef FILTER_WEIGHT_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end
`endif

  always_comb begin
    weights = '0;
    for (int i = 0; i < N; i++) begin
      weights[i*WIDTH +: WIDTH] = r_bank[r_active][i];
    end
  end

  assign in_ready      = (r_state != FULL);
  assign shadow_full   = (r_state == FULL);
  assign load_err      = r_load_err;
  assign active_bank   = r_active;
  assign weights_valid = r_weights_valid;

endmodule
